// File: rtl/controle_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, timestep states and ALU codes.
package controle_pkg;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [3:0] OP_MV   = 4'b0000;
    localparam logic [3:0] OP_MVI  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_LD   = 4'b0100;
    localparam logic [3:0] OP_ST   = 4'b0101;
    localparam logic [3:0] OP_MVNZ = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_SLT = 2'b10;

endpackage

// File: rtl/dec_onehot.sv
// Binary-to-one-hot register select decoder; all outputs low when not enabled.
module dec_onehot #(
    parameter int RW   = 3,
    parameter int NREG = 8
) (
    input  logic            en,
    input  logic [RW-1:0]   sel,
    output logic [NREG-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en)
            onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Multi-cycle control unit: latches {op,X,Y} in T0 and sequences it over T1..T3.
// Memory wait states (LD in T2, ST in T3 held until mem_ack) enabled by `define CONTROLE_MEM_WAIT_EN.
module controle_multiciclo
    import controle_pkg::*;
#(
    parameter int NREG = 8,
    parameter int OPW  = 4,
    localparam int RW  = $clog2(NREG),
    localparam int IRW = OPW + 2*RW
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            run,
    input  logic [IRW-1:0]  ir,
    input  logic            zero,
    input  logic            mem_ack,
    output logic [NREG-1:0] r_in,
    output logic [NREG-1:0] r_out,
    output logic            a_in,
    output logic            g_in,
    output logic            g_out,
    output logic            din_out,
    output logic [1:0]      alu_op,
    output logic            addr_in,
    output logic            dout_in,
    output logic            wren,
    output logic            done,
    output logic            illegal
);

    state_t          state, next_state;
    logic [IRW-1:0]  ir_q;
    logic [OPW-1:0]  op;
    logic [RW-1:0]   x, y;
    logic            rin_en, rout_en;
    logic [RW-1:0]   rin_sel, rout_sel;
    logic            ack;

    assign op = ir_q[IRW-1 -: OPW];
    assign x  = ir_q[2*RW-1 -: RW];
    assign y  = ir_q[RW-1:0];

`ifdef CONTROLE_MEM_WAIT_EN
    assign ack = mem_ack;
`else
    logic unused_mem_ack;
    assign unused_mem_ack = mem_ack;
    assign ack = 1'b1;
`endif

    // The instruction is only captured when an idle T0 sees run; later ir changes are ignored.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= T0;
            ir_q  <= '0;
        end else begin
            state <= next_state;
            if (state == T0 && run)
                ir_q <= ir;
        end
    end

    always_comb begin
        next_state = state;
        rin_en     = 1'b0;
        rout_en    = 1'b0;
        rin_sel    = '0;
        rout_sel   = '0;
        a_in       = 1'b0;
        g_in       = 1'b0;
        g_out      = 1'b0;
        din_out    = 1'b0;
        alu_op     = ALU_ADD;
        addr_in    = 1'b0;
        dout_in    = 1'b0;
        wren       = 1'b0;
        done       = 1'b0;
        illegal    = 1'b0;

        case (state)
            T0: begin
                if (run)
                    next_state = T1;
            end

            T1: begin
                case (op)
                    OPW'(OP_MV): begin
                        rout_en    = 1'b1;
                        rout_sel   = y;
                        rin_en     = 1'b1;
                        rin_sel    = x;
                        done       = 1'b1;
                        next_state = T0;
                    end
                    OPW'(OP_MVI): begin
                        din_out    = 1'b1;
                        rin_en     = 1'b1;
                        rin_sel    = x;
                        done       = 1'b1;
                        next_state = T0;
                    end
                    OPW'(OP_ADD), OPW'(OP_SUB), OPW'(OP_SLT): begin
                        rout_en    = 1'b1;
                        rout_sel   = x;
                        a_in       = 1'b1;
                        next_state = T2;
                    end
                    OPW'(OP_LD), OPW'(OP_ST): begin
                        rout_en    = 1'b1;
                        rout_sel   = y;
                        addr_in    = 1'b1;
                        next_state = T2;
                    end
                    OPW'(OP_MVNZ): begin
                        rout_en    = !zero;
                        rout_sel   = y;
                        rin_en     = !zero;
                        rin_sel    = x;
                        done       = 1'b1;
                        next_state = T0;
                    end
                    default: begin
                        done       = 1'b1;
                        illegal    = 1'b1;
                        next_state = T0;
                    end
                endcase
            end

            T2: begin
                case (op)
                    OPW'(OP_ADD), OPW'(OP_SUB), OPW'(OP_SLT): begin
                        rout_en    = 1'b1;
                        rout_sel   = y;
                        g_in       = 1'b1;
                        if (op == OPW'(OP_SUB))
                            alu_op = ALU_SUB;
                        else if (op == OPW'(OP_SLT))
                            alu_op = ALU_SLT;
                        next_state = T3;
                    end
                    OPW'(OP_LD): begin
                        if (ack)
                            next_state = T3;
                    end
                    OPW'(OP_ST): begin
                        rout_en    = 1'b1;
                        rout_sel   = x;
                        dout_in    = 1'b1;
                        next_state = T3;
                    end
                    default: next_state = T0;
                endcase
            end

            T3: begin
                case (op)
                    OPW'(OP_ADD), OPW'(OP_SUB), OPW'(OP_SLT): begin
                        g_out      = 1'b1;
                        rin_en     = 1'b1;
                        rin_sel    = x;
                        done       = 1'b1;
                        next_state = T0;
                    end
                    OPW'(OP_LD): begin
                        din_out    = 1'b1;
                        rin_en     = 1'b1;
                        rin_sel    = x;
                        done       = 1'b1;
                        next_state = T0;
                    end
                    // The store write strobe stays up until memory acknowledges it.
                    OPW'(OP_ST): begin
                        wren = 1'b1;
                        done = ack;
                        if (ack)
                            next_state = T0;
                    end
                    default: next_state = T0;
                endcase
            end

            default: next_state = T0;
        endcase
    end

    dec_onehot #(.RW(RW), .NREG(NREG)) u_dec_rin (
        .en     (rin_en),
        .sel    (rin_sel),
        .onehot (r_in)
    );

    dec_onehot #(.RW(RW), .NREG(NREG)) u_dec_rout (
        .en     (rout_en),
        .sel    (rout_sel),
        .onehot (r_out)
    );

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench for controle_multiciclo: directed plan steps then random instructions vs. a per-cycle model.
module tb_controle_multiciclo;

    localparam int NREG = 8;

    typedef struct packed {
        logic [NREG-1:0] r_in;
        logic [NREG-1:0] r_out;
        logic            a_in;
        logic            g_in;
        logic            g_out;
        logic            din_out;
        logic [1:0]      alu_op;
        logic            addr_in;
        logic            dout_in;
        logic            wren;
        logic            done;
        logic            illegal;
    } outv_t;

    logic            clock = 1'b0;
    logic            resetn = 1'b0;
    logic            run = 1'b0;
    logic [9:0]      ir = '0;
    logic            zero = 1'b0;
    logic            mem_ack = 1'b0;
    logic [NREG-1:0] r_in, r_out;
    logic            a_in, g_in, g_out, din_out;
    logic [1:0]      alu_op;
    logic            addr_in, dout_in, wren, done, illegal;

    int vectors = 0;
    int miscompares = 0;

    outv_t exp_q[$];
    logic  ack_q[$];

    controle_multiciclo #(.NREG(NREG), .OPW(4)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .run     (run),
        .ir      (ir),
        .zero    (zero),
        .mem_ack (mem_ack),
        .r_in    (r_in),
        .r_out   (r_out),
        .a_in    (a_in),
        .g_in    (g_in),
        .g_out   (g_out),
        .din_out (din_out),
        .alu_op  (alu_op),
        .addr_in (addr_in),
        .dout_in (dout_in),
        .wren    (wren),
        .done    (done),
        .illegal (illegal)
    );

    always #5 clock = ~clock;

    function automatic logic [NREG-1:0] oh(input int idx);
        logic [NREG-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic push(input outv_t v, input logic a);
        exp_q.push_back(v);
        ack_q.push_back(a);
    endtask

    // Per-cycle expectations of one instruction, derived from the opcode behaviour table.
    task automatic planInstr(input int op, input int x, input int y, input logic z, input int nwait);
        outv_t v;
        exp_q.delete();
        ack_q.delete();
        v = '0;
        if (op == 0) begin
            v.r_out = oh(y); v.r_in = oh(x); v.done = 1'b1;
            push(v, 1'($urandom));
        end else if (op == 1) begin
            v.din_out = 1'b1; v.r_in = oh(x); v.done = 1'b1;
            push(v, 1'($urandom));
        end else if (op == 2 || op == 3 || op == 7) begin
            v.r_out = oh(x); v.a_in = 1'b1;
            push(v, 1'($urandom));
            v = '0;
            v.r_out = oh(y); v.g_in = 1'b1;
            v.alu_op = (op == 2) ? 2'd0 : (op == 3) ? 2'd1 : 2'd2;
            push(v, 1'($urandom));
            v = '0;
            v.g_out = 1'b1; v.r_in = oh(x); v.done = 1'b1;
            push(v, 1'($urandom));
        end else if (op == 4) begin
            v.r_out = oh(y); v.addr_in = 1'b1;
            push(v, 1'($urandom));
            v = '0;
`ifdef CONTROLE_MEM_WAIT_EN
            for (int i = 0; i < nwait; i++) push(v, 1'b0);
            push(v, 1'b1);
`else
            push(v, 1'($urandom));
`endif
            v.din_out = 1'b1; v.r_in = oh(x); v.done = 1'b1;
            push(v, 1'($urandom));
        end else if (op == 5) begin
            v.r_out = oh(y); v.addr_in = 1'b1;
            push(v, 1'($urandom));
            v = '0;
            v.r_out = oh(x); v.dout_in = 1'b1;
            push(v, 1'($urandom));
            v = '0;
            v.wren = 1'b1;
`ifdef CONTROLE_MEM_WAIT_EN
            for (int i = 0; i < nwait; i++) push(v, 1'b0);
            v.done = 1'b1;
            push(v, 1'b1);
`else
            v.done = 1'b1;
            push(v, 1'($urandom));
`endif
        end else if (op == 6) begin
            if (!z) begin
                v.r_out = oh(y); v.r_in = oh(x);
            end
            v.done = 1'b1;
            push(v, 1'($urandom));
        end else begin
            v.done = 1'b1; v.illegal = 1'b1;
            push(v, 1'($urandom));
        end
    endtask

    task automatic checkOutput(input string tag, input outv_t expv);
        outv_t obs;
        obs = {r_in, r_out, a_in, g_in, g_out, din_out, alu_op, addr_in, dout_in, wren, done, illegal};
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic idleCycle(input string tag);
        @(negedge clock);
        run = 1'b0;
        ir = 10'($urandom);
        zero = 1'($urandom);
        mem_ack = 1'($urandom);
        #1;
        checkOutput(tag, '0);
    endtask

    // One T0 capture cycle followed by every expected cycle of the instruction.
    task automatic applyStimulus(input string tag, input int op, input int x, input int y,
                                 input logic z, input int nwait);
        planInstr(op, x, y, z, nwait);
        @(negedge clock);
        run = 1'b1;
        ir = {4'(op), 3'(x), 3'(y)};
        zero = z;
        mem_ack = 1'($urandom);
        #1;
        checkOutput({tag, "_t0"}, '0);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clock);
            run = 1'($urandom);
            ir = 10'($urandom);
            zero = z;
            mem_ack = ack_q[i];
            #1;
            checkOutput($sformatf("%s_c%0d", tag, i + 1), exp_q[i]);
        end
    endtask

    initial begin
        outv_t v;
        resetn = 1'b0;
        run = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_state", '0);
        @(negedge clock);
        resetn = 1'b1;
        run = 1'b0;
        #1;
        checkOutput("after_reset", '0);

        applyStimulus("mvi_r0", 1, 0, 0, 1'b0, 0);
        applyStimulus("add_r1_r1", 2, 1, 1, 1'b0, 0);
        applyStimulus("mvnz_z1", 6, 2, 1, 1'b1, 0);
        applyStimulus("mvnz_z0", 6, 2, 1, 1'b0, 0);
        applyStimulus("illegal_1010", 10, 3, 5, 1'b0, 0);
        idleCycle("idle_after_illegal");
        applyStimulus("st_r3_r4", 5, 3, 4, 1'b0, 3);
        applyStimulus("ld_r5_r6", 4, 5, 6, 1'b0, 2);
        applyStimulus("slt_r7_r0", 7, 7, 0, 1'b0, 0);

        // SUB aborted by reset in T2: outputs must drop without waiting for a clock edge.
        @(negedge clock);
        run = 1'b1; ir = {4'd3, 3'd1, 3'd2}; #1;
        checkOutput("sub_abort_t0", '0);
        @(negedge clock);
        run = 1'b0; #1;
        v = '0; v.r_out = oh(1); v.a_in = 1'b1;
        checkOutput("sub_abort_t1", v);
        @(negedge clock);
        #1;
        v = '0; v.r_out = oh(2); v.g_in = 1'b1; v.alu_op = 2'd1;
        checkOutput("sub_abort_t2", v);
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("async_reset", '0);
        @(posedge clock);
        #1;
        checkOutput("reset_held", '0);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        checkOutput("reset_release", '0);
        applyStimulus("mv_after_reset", 0, 4, 6, 1'b0, 0);

        for (int n = 0; n < 300; n++) begin
            applyStimulus("rnd", $urandom_range(0, 15), $urandom_range(0, NREG - 1),
                          $urandom_range(0, NREG - 1), 1'($urandom), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)
                idleCycle("rnd_idle");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Parametrised multi-cycle control unit for the simple processor datapath: it latches a `III XXX YYY` instruction word, sequences it over up to four timesteps, and drives one-hot register enables, ALU, bus-select and memory-interface strobes. It generalises the 8-register, 10-bit-instruction controller to any power-of-two register count. It adds an internal instruction latch, a comparison (SLT) opcode, an illegal-opcode flag and optional memory wait states.

## Interface
Parameters:
- `NREG`, 8, number of general registers (power of two, ≥2); `RW = $clog2(NREG)`.
- `OPW`, 4, opcode width; `IRW = OPW + 2*RW` (10 at defaults).

Ports:
- `clock` in 1, single clock, rising edge.
- `resetn` in 1, reset, asynchronous, active-low.
- `run` in 1, start request; sampled only in T0.
- `ir` in IRW, instruction `{op, X, Y}`; captured into the internal IR on T0 & run.
- `zero` in 1, G-register zero flag for MVNZ.
- `mem_ack` in 1, memory completion; used only with `CONTROLE_MEM_WAIT_EN`.
- `r_in` out NREG, one-hot register load.
- `r_out` out NREG, one-hot register bus drive.
- `a_in`, `g_in`, `g_out`, `din_out` out 1, datapath strobes.
- `alu_op` out 2: 00 add, 01 sub, 10 slt.
- `addr_in`, `dout_in`, `wren` out 1, memory-interface strobes.
- `done` out 1, last cycle of the instruction.
- `illegal` out 1, pulses with `done` on an undefined opcode.

## Operation
- Opcodes: 0000 MV, 0001 MVI, 0010 ADD, 0011 SUB, 0100 LD, 0101 ST, 0110 MVNZ, 0111 SLT. 1000–1111 are illegal.
- States: T0 (idle), T1, T2, T3. T0→T1 on `run`; all other states →T0 after `done`.
- MV: T1: `r_out[Y]`, `r_in[X]`, `done`.
- MVI: T1: `din_out`, `r_in[X]`, `done`.
- ADD/SUB/SLT: T1: `r_out[X]`, `a_in`. T2: `r_out[Y]`, `g_in`, `alu_op`. T3: `g_out`, `r_in[X]`, `done`.
- LD: T1: `r_out[Y]`, `addr_in`. T2: idle (memory read). T3: `din_out`, `r_in[X]`, `done`.
- ST: T1: `r_out[Y]`, `addr_in`. T2: `r_out[X]`, `dout_in`. T3: `wren`, `done`.
- MVNZ: T1: if `!zero`, `r_out[Y]` and `r_in[X]`; `done` is asserted either way.
- Illegal: T1: `done`, `illegal`; no other strobe.
- At most one `r_in` bit and one `r_out` bit are ever high. X==Y is legal.

## Timing
- State and IR are registered. Outputs decode combinationally from state and IR, plus `zero`/`mem_ack` where listed.
- Latency in cycles after the T0 capture edge: MV/MVI/MVNZ/illegal 1; ALU ops, LD, ST 3 (without wait states).
- `run` held high: a new instruction is captured in the T0 cycle immediately following `done`. There is no back-to-back overlap; T0 always lasts at least one cycle.
- `ir` changes outside T0 are ignored.
- Reset (asynchronous, any state): state = T0, IR = 0, all outputs 0 immediately. An in-flight instruction is aborted with no `done`.

## Configuration
- `CONTROLE_MEM_WAIT_EN` defined:
  - LD stays in T2 until `mem_ack` = 1, then goes to T3.
  - ST holds T3 with `wren` = 1 until `mem_ack` = 1; `done` is asserted in the same cycle as the ack.
  - `mem_ack` high in the first cycle gives the same timing as the undefined build.
- Undefined: fixed timing; `mem_ack` is ignored.

## Structure
- `controle_pkg`: opcode localparams, state encoding (T0–T3), `alu_op` codes.
- Sub-module `dec_onehot` (`RW`→`NREG` one-hot decoder with enable), instanced twice, for `r_in` and `r_out`.

## Test plan
- Reset with `run` = 1, then MVI R0 (`ir` = 0001_000_000) → T1: `din_out` = 1, `r_in` = 8'h01, `done` = 1.
- ADD R1,R1 (0010_001_001) → T1 `r_out` = 8'h02 with `a_in`; T2 `r_out` = 8'h02, `g_in`, `alu_op` = 00; T3 `g_out`, `r_in` = 8'h02, `done`.
- MVNZ R2,R1 (0110_010_001): with `zero` = 1 → `done` only, `r_in` = 0; with `zero` = 0 → `r_out` = 8'h02, `r_in` = 8'h04.
- Opcode 1010 → one cycle with `done` = 1 and `illegal` = 1, back to T0.
- `CONTROLE_MEM_WAIT_EN`: ST R3,R4 with `mem_ack` low for 3 cycles → `wren` high for 4 cycles, `done` only in the ack cycle.
- Pull `resetn` low in T2 of SUB → all outputs 0 at once; after release, T0 and the next `run` starts cleanly.
